// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between the UART loader (0),
// cipher core (1) and UART dumper (2), with bounded ownership bursts and read-return tagging.
module ram_port_arbiter #(
    parameter int unsigned AW        = 15,
    parameter int unsigned DW        = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [2:0]      req,
    input  logic [2:0]      we_i,
    input  logic [3*AW-1:0] addr_i,
    input  logic [3*DW-1:0] wdata_i,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            ram_en,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_ARB, ST_OWN} state_t;

    state_t        r_state;
    logic [1:0]    r_owner;
    logic [1:0]    r_rr;
    logic [BW-1:0] r_burst;
    logic [RD_LAT:0] r_pv;
    logic [1:0]    r_pid [RD_LAT+1];

    logic          w_req_own;
    logic          w_we;
    logic          w_grant;
    logic [1:0]    w_c1;
    logic [1:0]    w_c2;
    logic [1:0]    w_pick;
    logic [1:0]    w_next_rr;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    function automatic logic [1:0] mod3_inc(input logic [1:0] a);
        return (a == 2'd2) ? 2'd0 : a + 2'd1;
    endfunction

    function automatic logic bit_of(input logic [2:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[0];
            2'd1:    return v[1];
            default: return v[2];
        endcase
    endfunction

    // First requester at or after the round-robin pointer, wrapping modulo 3.
    always_comb begin
        w_c1   = mod3_inc(r_rr);
        w_c2   = mod3_inc(w_c1);
        w_pick = w_c2;
        if (bit_of(req, r_rr)) begin
            w_pick = r_rr;
        end else if (bit_of(req, w_c1)) begin
            w_pick = w_c1;
        end
    end

    always_comb begin
        w_req_own = bit_of(req, r_owner);
        w_we      = bit_of(we_i, r_owner);
        w_grant   = (r_state == ST_OWN) && w_req_own;
        w_next_rr = mod3_inc(r_owner);
        gnt       = '0;
        case (r_owner)
            2'd0:    begin w_addr = addr_i[0 +: AW];    w_wdata = wdata_i[0 +: DW];    end
            2'd1:    begin w_addr = addr_i[AW +: AW];   w_wdata = wdata_i[DW +: DW];   end
            default: begin w_addr = addr_i[2*AW +: AW]; w_wdata = wdata_i[2*DW +: DW]; end
        endcase
        if (w_grant) begin
            case (r_owner)
                2'd0:    gnt = 3'b001;
                2'd1:    gnt = 3'b010;
                default: gnt = 3'b100;
            endcase
        end
    end

    // Read returns are tagged by the id travelling down the pipeline.
    always_comb begin
        rvalid = '0;
        if (r_pv[RD_LAT]) begin
            case (r_pid[RD_LAT])
                2'd0:    rvalid = 3'b001;
                2'd1:    rvalid = 3'b010;
                default: rvalid = 3'b100;
            endcase
        end
    end

    assign rdata = ram_dout;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state  <= ST_ARB;
            r_owner  <= '0;
            r_rr     <= '0;
            r_burst  <= '0;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            r_pv     <= '0;
            for (int i = 0; i <= int'(RD_LAT); i++) begin
                r_pid[i] <= '0;
            end
        end else begin
            ram_en   <= w_grant;
            ram_we   <= w_grant & w_we;
            if (w_grant) begin
                ram_addr <= w_addr;
                ram_din  <= w_wdata;
            end
            r_pv[0]  <= w_grant & ~w_we;
            r_pid[0] <= r_owner;
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pid[i] <= r_pid[i-1];
            end
            case (r_state)
                ST_ARB: begin
                    if (|req) begin
                        r_owner <= w_pick;
                        r_burst <= '0;
                        r_state <= ST_OWN;
                    end
                end
                default: begin
                    if (!w_req_own) begin
                        r_state <= ST_ARB;
                        r_rr    <= w_next_rr;
                    end else begin
                        r_burst <= r_burst + BW'(1);
                        // Grant that completes the burst also releases ownership.
                        if (r_burst == BW'(MAX_BURST - 1)) begin
                            r_state <= ST_ARB;
                            r_rr    <= w_next_rr;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural one-cycle-latency RAM.
module tb_ram_port_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 8;
    localparam int N_SWEEP = 6416;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic [2:0]      req     = '0;
    logic [2:0]      we_i    = '0;
    logic [3*AW-1:0] addr_i  = '0;
    logic [3*DW-1:0] wdata_i = '0;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            ram_en;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;

    logic [DW-1:0]   mem [1 << AW];

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_BURST(16)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req      (req),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 sys_clk = ~sys_clk;

    // Read-first single-port RAM, one cycle latency.
    always @(posedge sys_clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 29) ^ (a >> 7) ^ 8'h5A);
    endfunction

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        req     = '0;
        we_i    = '0;
        cyc();
        cyc();
        sys_rst = 1'b0;
    endtask

    task automatic set_port(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we_i[k]             = we;
        addr_i[k*AW +: AW]  = a;
        wdata_i[k*DW +: DW] = d;
    endtask

    // Bounded wait until requester k is granted; returns in the grant cycle.
    task automatic wait_gnt(input int k);
        int n;
        n = 0;
        #1;
        while (gnt[k] !== 1'b1 && n < 64) begin
            cyc();
            #1;
            n++;
        end
        if (gnt[k] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_gnt%0d: gnt=%b after %0d cycles, required grant", k, gnt, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (gnt !== 3'b000)     begin errors++; $display("FAIL rst_gnt: got %b exp 000", gnt); end
        checks++; if (rvalid !== 3'b000)  begin errors++; $display("FAIL rst_rvalid: got %b exp 000", rvalid); end
        checks++; if (ram_en !== 1'b0)    begin errors++; $display("FAIL rst_ram_en: got %b exp 0", ram_en); end
        checks++; if (ram_we !== 1'b0)    begin errors++; $display("FAIL rst_ram_we: got %b exp 0", ram_we); end
        checks++; if (ram_addr !== '0)    begin errors++; $display("FAIL rst_ram_addr: got %h exp 0", ram_addr); end
        checks++; if (ram_din !== '0)     begin errors++; $display("FAIL rst_ram_din: got %h exp 0", ram_din); end
    endtask

    task automatic test_single_write();
        logic [2:0] rv_seen;
        cyc();
        req = 3'b001;
        set_port(0, 1'b1, 15'h0010, 8'hA5);
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL wr_arb_gnt: got %b exp 000", gnt); end
        cyc();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wr_gnt: got %b exp 001", gnt); end
        cyc();
        req = 3'b000;
        #1;
        checks++; if (ram_en !== 1'b1)      begin errors++; $display("FAIL wr_ram_en: got %b exp 1", ram_en); end
        checks++; if (ram_we !== 1'b1)      begin errors++; $display("FAIL wr_ram_we: got %b exp 1", ram_we); end
        checks++; if (ram_addr !== 15'h0010) begin errors++; $display("FAIL wr_ram_addr: got %h exp 0010", ram_addr); end
        checks++; if (ram_din !== 8'hA5)    begin errors++; $display("FAIL wr_ram_din: got %h exp a5", ram_din); end
        checks++; if (gnt !== 3'b000)       begin errors++; $display("FAIL wr_gnt_drop: got %b exp 000", gnt); end
        rv_seen = '0;
        repeat (4) begin
            cyc();
            rv_seen |= rvalid;
        end
        checks++; if (rv_seen !== 3'b000)   begin errors++; $display("FAIL wr_no_rvalid: got %b exp 000", rv_seen); end
        checks++; if (ram_en !== 1'b0)      begin errors++; $display("FAIL wr_idle_en: got %b exp 0", ram_en); end
        checks++; if (ram_addr !== 15'h0010) begin errors++; $display("FAIL wr_addr_hold: got %h exp 0010", ram_addr); end
    endtask

    task automatic test_core_read();
        cyc();
        req = 3'b001;
        set_port(0, 1'b1, 15'h1900, 8'h3C);
        wait_gnt(0);
        cyc();
        req = 3'b010;
        set_port(1, 1'b0, 15'h1900, 8'h00);
        wait_gnt(1);
        cyc();
        req = 3'b000;
        #1;
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rd_early: got %b exp 000", rvalid); end
        cyc();
        #1;
        checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL rd_rvalid: got %b exp 010", rvalid); end
        checks++; if (rdata !== 8'h3C)   begin errors++; $display("FAIL rd_rdata: got %h exp 3c", rdata); end
        cyc();
        #1;
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rd_late: got %b exp 000", rvalid); end
        repeat (3) cyc();
    endtask

    task automatic test_rr_burst();
        logic [2:0] exp_g;
        do_reset();
        req  = 3'b111;
        we_i = 3'b111;
        set_port(0, 1'b1, 15'h7F00, 8'h11);
        set_port(1, 1'b1, 15'h7F01, 8'h22);
        set_port(2, 1'b1, 15'h7F02, 8'h33);
        for (int c = 0; c < 55; c++) begin
            #1;
            exp_g = (c % 17 == 0) ? 3'b000 : (3'b001 << ((c / 17) % 3));
            checks++;
            if (gnt !== exp_g) begin errors++; $display("FAIL rr_cycle%0d: got %b exp %b", c, gnt, exp_g); end
            cyc();
        end
        req = 3'b000;
        repeat (3) cyc();
    endtask

    task automatic test_release();
        do_reset();
        req = 3'b101;
        set_port(0, 1'b1, 15'h0040, 8'h77);
        set_port(2, 1'b0, 15'h0041, 8'h00);
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rel_arb: got %b exp 000", gnt); end
        for (int n = 0; n < 3; n++) begin
            cyc();
            #1;
            checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rel_ld%0d: got %b exp 001", n, gnt); end
        end
        cyc();
        req = 3'b100;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rel_drop: got %b exp 000", gnt); end
        cyc();
        req = 3'b101;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rel_arb2: got %b exp 000", gnt); end
        cyc();
        #1;
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rel_dumper: got %b exp 100", gnt); end
        req = 3'b000;
        repeat (4) cyc();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        req = 3'b010;
        set_port(1, 1'b0, 15'h0100, 8'h00);
        cyc();
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rif_gnt1: got %b exp 010", gnt); end
        cyc();
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rif_gnt2: got %b exp 010", gnt); end
        cyc();
        sys_rst = 1'b1;
        req     = 3'b110;
        set_port(2, 1'b0, 15'h0200, 8'h00);
        cyc();
        sys_rst = 1'b0;
        #1;
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rif_rv0: got %b exp 000", rvalid); end
        checks++; if (ram_en !== 1'b0)   begin errors++; $display("FAIL rif_en0: got %b exp 0", ram_en); end
        checks++; if (gnt !== 3'b000)    begin errors++; $display("FAIL rif_arb: got %b exp 000", gnt); end
        cyc();
        #1;
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rif_rv1: got %b exp 000", rvalid); end
        checks++; if (ram_en !== 1'b0)   begin errors++; $display("FAIL rif_en1: got %b exp 0", ram_en); end
        checks++; if (ram_we !== 1'b0)   begin errors++; $display("FAIL rif_we1: got %b exp 0", ram_we); end
        checks++; if (gnt !== 3'b010)    begin errors++; $display("FAIL rif_next: got %b exp 010", gnt); end
        req = 3'b000;
        repeat (4) cyc();
    endtask

    task automatic test_sweep();
        int idx;
        int rd_issued;
        int rd_got;
        int budget;
        logic g;
        do_reset();
        idx    = 0;
        budget = 0;
        req    = 3'b001;
        set_port(0, 1'b1, '0, pat(0));
        while (idx < N_SWEEP && budget < 20000) begin
            #1;
            g = gnt[0];
            cyc();
            budget++;
            if (g) begin
                idx++;
                if (idx < N_SWEEP) set_port(0, 1'b1, AW'(idx), pat(idx));
                else req[0] = 1'b0;
            end
        end
        checks++;
        if (idx != N_SWEEP) begin errors++; $display("FAIL sweep_wr_count: got %0d exp %0d", idx, N_SWEEP); end
        req[0] = 1'b0;
        repeat (3) cyc();
        rd_issued = 0;
        rd_got    = 0;
        budget    = 0;
        req       = 3'b100;
        set_port(2, 1'b0, '0, 8'h00);
        while (rd_got < N_SWEEP && budget < 20000) begin
            #1;
            g = gnt[2];
            if (rvalid !== 3'b000) begin
                checks++;
                if (rvalid !== 3'b100 || rdata !== pat(rd_got)) begin
                    errors++;
                    $display("FAIL sweep_rd%0d: got rvalid=%b rdata=%h exp rvalid=100 rdata=%h", rd_got, rvalid, rdata, pat(rd_got));
                end
                rd_got++;
            end
            cyc();
            budget++;
            if (g) begin
                rd_issued++;
                if (rd_issued < N_SWEEP) set_port(2, 1'b0, AW'(rd_issued), 8'h00);
                else req[2] = 1'b0;
            end
        end
        checks++;
        if (rd_got != N_SWEEP) begin errors++; $display("FAIL sweep_rd_count: got %0d exp %0d", rd_got, N_SWEEP); end
        req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_core_read();
        test_rr_burst();
        test_release();
        test_reset_inflight();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
